// File: rtl/wb_pkg.sv
// Shared codes for the writeback select pipe: set conditions, output select
// codes, flag and control bit positions.
package wb_pkg;

    typedef enum logic [2:0] {
        SET_SEQ  = 3'd0,
        SET_SLT  = 3'd1,
        SET_SLE  = 3'd2,
        SET_SCO  = 3'd3,
        SET_SNE  = 3'd4,
        SET_SGE  = 3'd5,
        SET_SLTU = 3'd6,
        SET_SGT  = 3'd7
    } setop_e;

    typedef enum logic [2:0] {
        OUTSEL_BTR  = 3'd0,
        OUTSEL_SET1 = 3'd1,
        OUTSEL_SET0 = 3'd2,
        OUTSEL_LINK = 3'd3,
        OUTSEL_LBI  = 3'd4,
        OUTSEL_SLBI = 3'd5,
        OUTSEL_ALU  = 3'd6
    } outsel_e;

    // Bit positions inside flags = {carry, ofl, zero, neg}.
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OFL   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    // Bit positions inside ctl = {btr, set, link, lbi, slbi}.
    localparam int CTL_BTR  = 4;
    localparam int CTL_SET  = 3;
    localparam int CTL_LINK = 2;
    localparam int CTL_LBI  = 1;
    localparam int CTL_SLBI = 0;

endpackage

// File: rtl/wb_cond_eval.sv
// Combinational set-condition evaluator: maps a flag nibble and a set_op
// code to a single true/false result.
module wb_cond_eval
    import wb_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] set_op,
    output logic       cond
);

    logic carry;
    logic zero;
    logic lt;

    assign carry = flags[FLAG_CARRY];
    assign zero  = flags[FLAG_ZERO];
    assign lt    = flags[FLAG_NEG] ^ flags[FLAG_OFL];

    always_comb begin
        // NOTE: default first so every path assigns cond; otherwise a latch is inferred.
        cond = 1'b0;
        case (setop_e'(set_op))
            SET_SEQ:  cond = zero;
            SET_SLT:  cond = lt;
            SET_SLE:  cond = zero | lt;
            SET_SCO:  cond = carry;
            SET_SNE:  cond = ~zero;
            SET_SGE:  cond = ~lt;
            SET_SLTU: cond = ~carry;
            SET_SGT:  cond = ~zero & ~lt;
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_select_pipe.sv
// One-stage writeback select pipe with valid/ready handshake and flush.
// Define WB_SELECT_CCR_EN to add a stored 4-bit condition register.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       flags,
    input  logic [4:0]       ctl,
    input  logic [2:0]       set_op,
    input  logic             flags_wr,
    input  logic             use_ccr,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] pc_next,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       out_sel
);

    localparam int HALF = WIDTH / 2;

    logic             xfer;
    logic [3:0]       eval_flags;
    logic             cond;
    outsel_e          sel_next;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] opa_rev;

    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;

`ifdef WB_SELECT_CCR_EN
    logic [3:0] ccr;

    // A flushed request never commits, so it must not leave flags behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccr <= '0;
        end else if (xfer && !flush && flags_wr) begin
            ccr <= flags;
        end
    end

    assign eval_flags = use_ccr ? ccr : flags;
`else
    logic unused_ccr_ctl;

    assign unused_ccr_ctl = flags_wr ^ use_ccr;
    assign eval_flags     = flags;
`endif

    wb_cond_eval u_cond_eval (
        .flags  (eval_flags),
        .set_op (set_op),
        .cond   (cond)
    );

    always_comb begin
        opa_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            opa_rev[i] = opa[WIDTH-1-i];
        end
    end

    always_comb begin
        sel_next = OUTSEL_ALU;
        if (ctl[CTL_BTR]) begin
            sel_next = OUTSEL_BTR;
        end else if (ctl[CTL_SET]) begin
            sel_next = cond ? OUTSEL_SET1 : OUTSEL_SET0;
        end else if (ctl[CTL_LINK]) begin
            sel_next = OUTSEL_LINK;
        end else if (ctl[CTL_LBI]) begin
            sel_next = OUTSEL_LBI;
        end else if (ctl[CTL_SLBI]) begin
            sel_next = OUTSEL_SLBI;
        end
    end

    always_comb begin
        data_next = alu_res;
        case (sel_next)
            OUTSEL_BTR:  data_next = opa_rev;
            OUTSEL_SET1: data_next = WIDTH'(1);
            OUTSEL_SET0: data_next = '0;
            OUTSEL_LINK: data_next = pc_next;
            OUTSEL_LBI:  data_next = imm;
            OUTSEL_SLBI: data_next = (opa << HALF) | {{HALF{1'b0}}, imm[HALF-1:0]};
            OUTSEL_ALU:  data_next = alu_res;
            default:     data_next = alu_res;
        endcase
    end

    // Flush beats a same-cycle transfer; data and select keep their last
    // value whenever nothing new is loaded.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so outputs are never X after reset.
            out_valid <= 1'b0;
            wb_data   <= '0;
            out_sel   <= OUTSEL_ALU;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            wb_data   <= data_next;
            out_sel   <= sel_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe: directed cases plus random traffic
// against a behavioural model. Honours WB_SELECT_CCR_EN like the RTL.
module tb_wb_select_pipe;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       flags;
    logic [4:0]       ctl;
    logic [2:0]       set_op;
    logic             flags_wr;
    logic             use_ccr;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       out_sel;

    int checks   = 0;
    int failures = 0;

    // Model state: what the outputs must show, plus the stored flags.
    logic             m_valid;
    logic [2:0]       m_sel;
    logic [WIDTH-1:0] m_data;
    logic [3:0]       m_ccr;
    logic [WIDTH-1:0] delivered[$];

    always #5 clk = ~clk;

    wb_select_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flags     (flags),
        .ctl       (ctl),
        .set_op    (set_op),
        .flags_wr  (flags_wr),
        .use_ccr   (use_ccr),
        .alu_res   (alu_res),
        .opa       (opa),
        .pc_next   (pc_next),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .wb_data   (wb_data),
        .out_sel   (out_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {sel, data} for one request, straight from the selection rules.
    function automatic logic [WIDTH+2:0] ref_wb(input logic [4:0] c, input logic [3:0] f,
                                                input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] im,
                                                input logic [WIDTH-1:0] alu);
        logic carry, zero, lt, cnd;
        int sel;
        logic [WIDTH-1:0] d;
        carry = f[3];
        zero  = f[1];
        lt    = (f[0] != f[2]);
        case (op)
            3'd0: cnd = zero;
            3'd1: cnd = lt;
            3'd2: cnd = zero || lt;
            3'd3: cnd = carry;
            3'd4: cnd = !zero;
            3'd5: cnd = !lt;
            3'd6: cnd = !carry;
            default: cnd = !zero && !lt;
        endcase
        if (c[4])      sel = 0;
        else if (c[3]) sel = cnd ? 1 : 2;
        else if (c[2]) sel = 3;
        else if (c[1]) sel = 4;
        else if (c[0]) sel = 5;
        else           sel = 6;
        d = '0;
        case (sel)
            0: for (int i = 0; i < WIDTH; i++) d[i] = a[WIDTH-1-i];
            1: d = 1;
            2: d = 0;
            3: d = pc;
            4: d = im;
            5: d = WIDTH'(a * (2 ** (WIDTH/2)) + (im % (2 ** (WIDTH/2))));
            default: d = alu;
        endcase
        return {sel[2:0], d};
    endfunction

    // One clock: predict, let the edge happen, compare on the falling edge.
    task automatic cycle();
        logic [WIDTH+2:0] r;
        logic [3:0] fe;
        if (rst_n && !flush && out_valid && out_ready) delivered.push_back(wb_data);
        fe = flags;
`ifdef WB_SELECT_CCR_EN
        if (use_ccr) fe = m_ccr;
`endif
        r = ref_wb(ctl, fe, set_op, opa, pc_next, imm, alu_res);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 3'd6;
            m_ccr   = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            {m_sel, m_data} = r;
            if (flags_wr) m_ccr = flags;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_sel",   32'(out_sel),   32'(m_sel));
        check("wb_data",   32'(wb_data),   32'(m_data));
        check("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
    endtask

    task automatic idle();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ctl       = '0;
        flags     = '0;
        set_op    = '0;
        flags_wr  = 1'b0;
        use_ccr   = 1'b0;
        alu_res   = '0;
        opa       = '0;
        pc_next   = '0;
        imm       = '0;
    endtask

    initial begin
        idle();
        m_valid = 1'b0;
        m_sel   = 3'd6;
        m_data  = '0;
        m_ccr   = '0;

        // Reset state, then in_ready right after release.
        rst_n = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        cycle();
        cycle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(out_sel),   32'd6);
        check("rst_data",  32'(wb_data),   32'd0);
        idle();
        out_ready = 1'b0;
        cycle();
        check("ready_after_rst", 32'(in_ready), 32'd1);
        idle();

        // Set ops.
        in_valid = 1'b1;
        ctl      = 5'b01000;
        set_op   = 3'd1;
        flags    = 4'b0001;
        cycle();
        check("slt_sel",  32'(out_sel), 32'd1);
        check("slt_data", 32'(wb_data), 32'h0001);
        set_op = 3'd6;
        flags  = 4'b1000;
        cycle();
        check("sltu_sel",  32'(out_sel), 32'd2);
        check("sltu_data", 32'(wb_data), 32'h0000);

        // Priority and slbi packing.
        ctl = 5'b11111;
        opa = 16'h0001;
        cycle();
        check("btr_sel",  32'(out_sel), 32'd0);
        check("btr_data", 32'(wb_data), 32'h8000);
        ctl = 5'b00001;
        opa = 16'h00AB;
        imm = 16'h12CD;
        cycle();
        check("slbi_sel",  32'(out_sel), 32'd5);
        check("slbi_data", 32'(wb_data), 32'hABCD);

        // Backpressure: three requests, two stalled cycles, in-order delivery.
        in_valid = 1'b0;
        cycle();
        delivered.delete();
        ctl       = '0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        alu_res   = 16'h1111;
        cycle();
        alu_res = 16'h2222;
        for (int s = 0; s < 2; s++) begin
            cycle();
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_hold",  32'(wb_data),  32'h1111);
        end
        out_ready = 1'b1;
        cycle();
        alu_res = 16'h3333;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        check("bp_count", 32'(delivered.size()), 32'd3);
        for (int k = 0; k < 3 && k < delivered.size(); k++) begin
            check("bp_order", 32'(delivered[k]), 32'h1111 * (k + 1));
        end

        // Flush overrides a same-cycle transfer.
        in_valid = 1'b1;
        alu_res  = 16'h4444;
        cycle();
        flush   = 1'b1;
        alu_res = 16'h5555;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_keep",  32'(wb_data),   32'h4444);
        flush = 1'b0;

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sel",   32'(out_sel),   32'd6);
        check("midrst_data",  32'(wb_data),   32'd0);
        idle();

        // Condition register: store zero=1, then evaluate SEQ from it.
        in_valid = 1'b1;
        flags_wr = 1'b1;
        flags    = 4'b0010;
        cycle();
        flags_wr = 1'b0;
        flags    = 4'b0000;
        ctl      = 5'b01000;
        set_op   = 3'd0;
        use_ccr  = 1'b1;
        cycle();
`ifdef WB_SELECT_CCR_EN
        check("ccr_seq", 32'(wb_data), 32'd1);
`else
        check("ccr_seq", 32'(wb_data), 32'd0);
`endif
        idle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            ctl       = 5'($urandom & $urandom);
            flags     = 4'($urandom);
            set_op    = 3'($urandom);
            flags_wr  = 1'($urandom);
            use_ccr   = 1'($urandom);
            alu_res   = WIDTH'($urandom);
            opa       = WIDTH'($urandom);
            pc_next   = WIDTH'($urandom);
            imm       = WIDTH'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_select_pipe.md
WB_SELECT_PIPE -- requirements
Module: wb_select_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width (even, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream holds a valid writeback request.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port flags  input  4  {carry, ofl, zero, neg} from the ALU.
REQ-007 SHALL have port ctl  input  5  {btr, set, link, lbi, slbi}.
REQ-008 SHALL have port set_op  input  3  condition code (see REQ-014).
REQ-009 SHALL have port flags_wr  input  1  request updates the condition register.
REQ-010 SHALL have port use_ccr  input  1  set evaluates the stored flags instead of the live flags.
REQ-011 SHALL have ports alu_res, opa, pc_next, imm  input  WIDTH each  candidate writeback sources.
REQ-012 SHALL have ports out_valid  output  1, out_ready  input  1, flush  input  1, wb_data  output  WIDTH, out_sel  output  3.

Function
REQ-013 in_ready SHALL be !out_valid | out_ready; a transfer occurs when in_valid & in_ready.
REQ-014 set_op SHALL select the condition (n^o = neg^ofl):
- 0 SEQ: zero
- 1 SLT: n^o
- 2 SLE: zero | n^o
- 3 SCO: carry
- 4 SNE: !zero
- 5 SGE: !(n^o)
- 6 SLTU: !carry
- 7 SGT: !zero & !(n^o)
REQ-015 On a transfer, out_sel SHALL register the first true term in this priority: btr 0; set&cond 1; set&!cond 2; link 3; lbi 4; slbi 5; otherwise 6.
REQ-016 wb_data SHALL register, per out_sel:
- 0: opa bit-reversed
- 1: 1
- 2: 0
- 3: pc_next
- 4: imm
- 5: (opa << WIDTH/2) | imm[WIDTH/2-1:0]
- 6: alu_res
REQ-017 Latency SHALL be exactly one cycle from the transfer to out_valid=1.
REQ-018 While out_valid & !out_ready, wb_data and out_sel SHALL hold stable.
REQ-019 A simultaneous drain and new transfer SHALL load the new request with out_valid staying 1 (full throughput).
REQ-020 flush SHALL clear out_valid next cycle and SHALL override any same-cycle transfer; it SHALL NOT alter the condition register.
REQ-021 wb_data and out_sel SHALL be don't-care-free: they retain their last value when out_valid=0.

Reset
REQ-022 When rst_n=0 at a clock edge, the block SHALL set out_valid=0, wb_data=0, out_sel=6 and the condition register=0, taking priority over flush and transfers.
REQ-023 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-024 Macro WB_SELECT_CCR_EN SHALL compile in a 4-bit condition register.
- With the macro: the register loads flags on a transfer with flags_wr=1, and a set with use_ccr=1 evaluates the register value as it stood before that transfer.
- Without the macro: no register exists, flags_wr and use_ccr are ignored, and evaluation always uses the live flags.

Structure
REQ-025 Package wb_pkg SHALL hold the set_op codes, the out_sel codes (OUTSEL_BTR..OUTSEL_ALU) and the flag bit indices.
REQ-026 Condition evaluation SHALL be a combinational sub-module wb_cond_eval (flags, set_op -> cond); all registers SHALL live in wb_select_pipe.

Verification
REQ-027 Set op: WIDTH=16, set=1, set_op=1, flags neg=1 ofl=0 -> next cycle out_sel=1, wb_data=0x0001; then set_op=6, carry=1 -> out_sel=2, wb_data=0x0000.
REQ-028 Priority: ctl=all ones, opa=0x0001 -> out_sel=0, wb_data=0x8000; slbi only, opa=0x00AB, imm=0x12CD -> out_sel=5, wb_data=0xABCD.
REQ-029 Backpressure: 3 back-to-back requests with out_ready low for 2 cycles -> in_ready=0 during the stall, output held, and all 3 results delivered in order with none lost or duplicated.
REQ-030 Flush/reset: flush asserted with in_valid=1 -> out_valid=0 next cycle; rst_n=0 mid-stall -> out_valid=0, out_sel=6, wb_data=0.
REQ-031 CCR (macro on): transfer with flags_wr=1, zero=1, then a transfer with set_op=0, use_ccr=1, live zero=0 -> wb_data=1; with the macro off -> wb_data=0.
